// File: rtl/pattern_bank_pkg.sv
// Shared types and constants for the pattern_bank channel array.
package pattern_bank_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_ZERO  = 2'd0,
        MODE_ONES  = 2'd1,
        MODE_HOLD  = 2'd2,
        MODE_COUNT = 2'd3
    } mode_e;

endpackage

// File: rtl/pattern_chan.sv
// One output channel: shadow config, active config/counter, registered output and wrap pulse.
module pattern_chan
    import pattern_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [MODE_W-1:0] i_wr_mode,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_commit,
    input  logic              i_run,
    output logic [WIDTH-1:0]  o_value,
    output logic              o_wrap
);

    typedef struct packed {
        mode_e            mode;
        logic [WIDTH-1:0] data;
    } chan_cfg_t;

    chan_cfg_t        r_shadow;
    chan_cfg_t        r_active;
    logic [WIDTH-1:0] r_out;
    logic             r_wrap;

    chan_cfg_t        w_wr_cfg;
    chan_cfg_t        w_commit_cfg;
    chan_cfg_t        w_active_next;
    logic [WIDTH-1:0] w_out_next;
    logic             w_wrap_next;

    always_comb begin
        w_wr_cfg.mode = mode_e'(i_wr_mode);
        w_wr_cfg.data = i_wr_data;
        // A write landing in the commit cycle is committed along with the rest.
        w_commit_cfg  = i_wr_en ? w_wr_cfg : r_shadow;
        w_active_next = r_active;
        w_wrap_next   = 1'b0;
        if (i_commit) begin
            w_active_next = w_commit_cfg;
        end else if (i_run && r_active.mode == MODE_COUNT) begin
            w_active_next.data = r_active.data + WIDTH'(1);
            w_wrap_next        = &r_active.data;
        end
        case (w_active_next.mode)
            MODE_ZERO: w_out_next = '0;
            MODE_ONES: w_out_next = '1;
            default:   w_out_next = w_active_next.data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_out    <= '0;
            r_wrap   <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_shadow <= w_wr_cfg;
            end
            r_active <= w_active_next;
            r_out    <= w_out_next;
            r_wrap   <= w_wrap_next;
        end
    end

    assign o_value = r_out;
    assign o_wrap  = r_wrap;

endmodule

// File: rtl/pattern_bank.sv
// Bank of NUM_CH programmable pattern channels with shadowed config and a global commit.
module pattern_bank
    import pattern_bank_pkg::*;
#(
    parameter  int NUM_CH = 3,
    parameter  int WIDTH  = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [CH_W-1:0]         i_cfg_ch,
    input  logic [MODE_W-1:0]       i_cfg_mode,
    input  logic [WIDTH-1:0]        i_cfg_data,
    input  logic                    i_commit,
    input  logic                    i_run,
    output logic [NUM_CH*WIDTH-1:0] o_ch,
    output logic [NUM_CH-1:0]       o_wrap,
    output logic                    o_cfg_err
);

    logic              r_cfg_ready;
    logic              r_cfg_err;
    logic              w_accept;
    logic              w_in_range;
    logic [NUM_CH-1:0] w_wr_en;

    assign w_accept   = i_cfg_valid & r_cfg_ready;
    assign w_in_range = int'(i_cfg_ch) < NUM_CH;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign w_wr_en[gi] = w_accept && w_in_range && (int'(i_cfg_ch) == gi);

            pattern_chan #(
                .WIDTH (WIDTH)
            ) u_chan (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_wr_en   (w_wr_en[gi]),
                .i_wr_mode (i_cfg_mode),
                .i_wr_data (i_cfg_data),
                .i_commit  (i_commit),
                .i_run     (i_run),
                .o_value   (o_ch[gi*WIDTH +: WIDTH]),
                .o_wrap    (o_wrap[gi])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= w_accept & ~w_in_range;
        end
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pattern_bank.sv
// Self-checking bench for pattern_bank: per-cycle reference model plus directed literal checks.
module tb_pattern_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Default instance: NUM_CH=3, WIDTH=8
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_data = '0;
    logic        commit = 1'b0;
    logic        run = 1'b0;
    logic [23:0] och;
    logic [2:0]  owrap;
    logic        cfg_err;

    // Second instance: NUM_CH=5, WIDTH=4
    logic        cfg_valid2 = 1'b0;
    logic        cfg_ready2;
    logic [2:0]  cfg_ch2 = '0;
    logic [1:0]  cfg_mode2 = '0;
    logic [3:0]  cfg_data2 = '0;
    logic        commit2 = 1'b0;
    logic        run2 = 1'b0;
    logic [19:0] och2;
    logic [4:0]  owrap2;
    logic        cfg_err2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pattern_bank #(.NUM_CH(3), .WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
        .i_cfg_ch(cfg_ch), .i_cfg_mode(cfg_mode), .i_cfg_data(cfg_data),
        .i_commit(commit), .i_run(run),
        .o_ch(och), .o_wrap(owrap), .o_cfg_err(cfg_err)
    );

    pattern_bank #(.NUM_CH(5), .WIDTH(4)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cfg_valid(cfg_valid2), .o_cfg_ready(cfg_ready2),
        .i_cfg_ch(cfg_ch2), .i_cfg_mode(cfg_mode2), .i_cfg_data(cfg_data2),
        .i_commit(commit2), .i_run(run2),
        .o_ch(och2), .o_wrap(owrap2), .o_cfg_err(cfg_err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for the default instance: shadow and active config per channel.
    int         m_sh_mode [3];
    int         m_sh_data [3];
    int         m_act_mode[3];
    int         m_act_val [3];
    logic [2:0] m_wrap;
    logic       m_err;
    logic       m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_sh_mode[k] = 0; m_sh_data[k] = 0; m_act_mode[k] = 0; m_act_val[k] = 0;
            end
            m_wrap = '0; m_err = 1'b0; m_ready = 1'b0;
        end else begin
            m_wrap = '0;
            m_err  = 1'b0;
            if (cfg_valid && m_ready) begin
                if (cfg_ch < 3) begin
                    m_sh_mode[cfg_ch] = int'(cfg_mode);
                    m_sh_data[cfg_ch] = int'(cfg_data);
                end else begin
                    m_err = 1'b1;
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (commit) begin
                    m_act_mode[k] = m_sh_mode[k];
                    m_act_val[k]  = m_sh_data[k];
                end else if (run && m_act_mode[k] == 3) begin
                    m_act_val[k] = (m_act_val[k] + 1) % 256;
                    if (m_act_val[k] == 0) m_wrap[k] = 1'b1;
                end
            end
            m_ready = 1'b1;
        end
    end

    function automatic logic [7:0] m_out(input int k);
        case (m_act_mode[k])
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'(m_act_val[k]);
        endcase
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) chk($sformatf("ch%0d", k), 32'(och[k*8 +: 8]), 32'(m_out(k)));
        chk("wrap", 32'(owrap), 32'(m_wrap));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
    end

    task automatic cyc(input logic v, input logic [1:0] ch, input logic [1:0] mode,
                       input logic [7:0] data, input logic cm, input logic rn);
        cfg_valid = v; cfg_ch = ch; cfg_mode = mode; cfg_data = data; commit = cm; run = rn;
        @(posedge clk);
        #2;
    endtask

    task automatic cyc2(input logic v, input logic [2:0] ch, input logic [1:0] mode,
                        input logic [3:0] data, input logic cm, input logic rn);
        cfg_valid2 = v; cfg_ch2 = ch; cfg_mode2 = mode; cfg_data2 = data; commit2 = cm; run2 = rn;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_och", 32'(och), 32'h0);
        chk("rst_wrap", 32'(owrap), 32'h0);
        chk("rst_err", 32'(cfg_err), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(cfg_ready), 32'h0);
        @(posedge clk);
        #2;
        chk("ready_after_edge", 32'(cfg_ready), 32'h1);

        // Writes without commit leave outputs untouched.
        cyc(1, 2'd0, 2'd0, 8'h00, 0, 0);
        cyc(1, 2'd1, 2'd1, 8'h00, 0, 0);
        cyc(1, 2'd2, 2'd2, 8'hA5, 0, 0);
        chk("no_commit_och", 32'(och), 32'h0);
        cyc(0, 2'd0, 2'd0, 8'h00, 1, 0);
        chk("commit_och", 32'(och), 32'hA5FF00);

        // Count through a wrap on channel 1, then pause.
        cyc(1, 2'd1, 2'd3, 8'hFD, 0, 0);
        cyc(0, 2'd0, 2'd0, 8'h00, 1, 1);
        chk("cnt_FD", 32'(och[15:8]), 32'hFD);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        chk("cnt_FE", 32'(och[15:8]), 32'hFE);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        chk("cnt_FF", 32'(och[15:8]), 32'hFF);
        chk("no_wrap_FF", 32'(owrap), 32'h0);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        chk("cnt_00", 32'(och[15:8]), 32'h00);
        chk("wrap_pulse", 32'(owrap), 32'b010);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 0);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 0);
        chk("paused", 32'(och[15:8]), 32'h00);
        chk("wrap_once", 32'(owrap), 32'h0);

        // Write-through commit with run high: load only.
        cyc(1, 2'd2, 2'd3, 8'h10, 1, 1);
        chk("wt_commit", 32'(och[23:16]), 32'h10);

        // Out-of-range write.
        cyc(1, 2'd3, 2'd1, 8'h55, 0, 0);
        chk("err_pulse", 32'(cfg_err), 32'h1);
        cyc(0, 2'd0, 2'd0, 8'h00, 1, 0);
        chk("err_clear", 32'(cfg_err), 32'h0);
        chk("bad_write_ignored", 32'(och), 32'h10FD00);

        // Second instance: NUM_CH=5, WIDTH=4.
        cyc2(1, 3'd5, 2'd3, 4'h0, 0, 0);
        chk("d2_err", 32'(cfg_err2), 32'h1);
        cyc2(1, 3'd4, 2'd3, 4'hF, 0, 0);
        chk("d2_err_clear", 32'(cfg_err2), 32'h0);
        cyc2(0, 3'd0, 2'd0, 4'h0, 1, 1);
        chk("d2_cnt_F", 32'(och2), 32'hF0000);
        cyc2(0, 3'd0, 2'd0, 4'h0, 0, 1);
        chk("d2_cnt_0", 32'(och2[19:16]), 32'h0);
        chk("d2_wrap", 32'(owrap2), 32'b10000);
        cyc2(0, 3'd0, 2'd0, 4'h0, 0, 1);
        chk("d2_cnt_1", 32'(och2[19:16]), 32'h1);
        chk("d2_wrap_clear", 32'(owrap2), 32'h0);
        cyc2(0, 3'd0, 2'd0, 4'h0, 0, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom % 2), 2'($urandom % 4), 2'($urandom % 4), 8'($urandom),
                1'(($urandom % 6) == 0), 1'(($urandom % 4) != 0));
        end

        // Asynchronous reset mid-count, then commit of the cleared shadows.
        cyc(1, 2'd0, 2'd3, 8'h80, 1, 1);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        chk("pre_reset_cnt", 32'(och[7:0]), 32'h82);
        rst_n = 1'b0;
        #1;
        chk("async_rst_och", 32'(och), 32'h0);
        chk("async_rst_ready", 32'(cfg_ready), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(0, 2'd0, 2'd0, 8'h00, 1, 1);
        chk("post_rst_commit", 32'(och), 32'h0);
        cyc(0, 2'd0, 2'd0, 8'h00, 0, 1);
        chk("post_rst_idle", 32'(och), 32'h0);
        chk("post_rst_wrap", 32'(owrap), 32'h0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
